// File: rtl/fetch_sequencer.sv
// Program counter and fetch controller for the program ROM; queues {pc, instruction} for decode.
// Latency ROM->instr_valid 1 cycle; push stalls (pc holds) when the buffer is full and decode is not popping.
// Optional breakpoint unit enabled by defining FETCH_BREAKPOINT_EN.
module fetch_sequencer #(
    parameter int ADDR_W   = 12,
    parameter int DATA_W   = 16,
    parameter int DEPTH    = 2,
    parameter int RESET_PC = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] code_address,
    input  logic [DATA_W-1:0] instruction,
    output logic [DATA_W-1:0] instr_out,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_addr,
    input  logic              halt_req,
`ifdef FETCH_BREAKPOINT_EN
    input  logic [ADDR_W-1:0] bp_addr,
    input  logic              bp_enable,
    input  logic              bp_resume,
`endif
    output logic              halted
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    typedef enum logic {RUN, HALT} state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] instr;
    } entry_t;

    state_t            state_q;
    logic [ADDR_W-1:0] pc_q, pc_d;
    entry_t            mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_q, rd_q;
    logic [CNT_W-1:0]  count_q;
    logic              full, pop, push, bp_hit;

`ifdef FETCH_BREAKPOINT_EN
    logic bp_halt_q;
    logic skip_q;
    // skip_q lets the breakpointed word through once after resume.
    assign bp_hit = (state_q == RUN) && bp_enable && (pc_q == bp_addr) && !skip_q;
`else
    assign bp_hit = 1'b0;
`endif

    always_comb begin
        full = (count_q == CNT_W'(DEPTH));
        pop  = instr_valid && instr_ready;
        push = (state_q == RUN) && !halt_req && !redirect_valid && !bp_hit && (!full || pop);
        pc_d = pc_q;
        if (redirect_valid) begin
            pc_d = redirect_addr;
        end else if (push) begin
            pc_d = pc_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            pc_q    <= ADDR_W'(RESET_PC);
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
`ifdef FETCH_BREAKPOINT_EN
            bp_halt_q <= 1'b0;
            skip_q    <= 1'b0;
`endif
        end else begin
            pc_q <= pc_d;
            // A redirect flushes everything, including a same-cycle pop.
            if (redirect_valid) begin
                wr_q    <= '0;
                rd_q    <= '0;
                count_q <= '0;
            end else begin
                if (push) begin
                    mem_q[wr_q] <= '{pc: pc_q, instr: instruction};
                    wr_q        <= wr_q + 1'b1;
                end
                if (pop) begin
                    rd_q <= rd_q + 1'b1;
                end
                count_q <= count_q + {{(CNT_W-1){1'b0}}, push} - {{(CNT_W-1){1'b0}}, pop};
            end

`ifdef FETCH_BREAKPOINT_EN
            if (skip_q && (pc_d != pc_q)) begin
                skip_q <= 1'b0;
            end
`endif
            case (state_q)
                RUN: begin
                    if (halt_req || bp_hit) begin
                        state_q <= HALT;
                    end
`ifdef FETCH_BREAKPOINT_EN
                    bp_halt_q <= bp_hit;
`endif
                end
                HALT: begin
`ifdef FETCH_BREAKPOINT_EN
                    if (bp_halt_q) begin
                        if (bp_resume && !halt_req) begin
                            state_q   <= RUN;
                            bp_halt_q <= 1'b0;
                            skip_q    <= 1'b1;
                        end
                    end else if (!halt_req) begin
                        state_q <= RUN;
                    end
`else
                    if (!halt_req) begin
                        state_q <= RUN;
                    end
`endif
                end
                default: state_q <= RUN;
            endcase
        end
    end

    assign code_address = pc_q;
    assign instr_out    = mem_q[rd_q].instr;
    assign instr_pc     = mem_q[rd_q].pc;
    assign instr_valid  = (count_q != '0);
    assign halted       = (state_q == HALT);

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        (push && full) |-> pop);
    a_head_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (instr_valid && !instr_ready && !redirect_valid) |=> ($stable(instr_out) && $stable(instr_pc)));

endmodule
